lut_iter_sequencer: RTL and testbench

- Controls iterative recurrences of the form (a_n, b_n) = f(a_n_1, b_n_1) across VECTOR lanes.
- Owns the lane state registers that feed the LUT update datapath.
- Accepts a job (initial vectors plus iteration count) over a valid/ready handshake, steps the state every UPDATE_LAT cycles, and returns the final vectors over a second handshake.
- Sits between the accelerator front-end and the LUT update unit, in place of a free-running delay stage.

---
 rtl/lut_iter_sequencer.sv | 163 ++++++++++++++++
 tb/tb_lut_iter_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_iter_sequencer.sv
// Iteration sequencer for LUT recurrences: owns lane state, commits a_next/b_next every UPDATE_LAT cycles.
// Optional early exit on a fixed point is enabled by defining SEQ_EARLY_EXIT_EN.
module lut_iter_sequencer #(
  parameter int REG_WIDTH  = 16,
  parameter int VECTOR     = 4,
  parameter int ITER_WIDTH = 8,
  parameter int UPDATE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [REG_WIDTH-1:0]  init_a [VECTOR],
  input  logic [REG_WIDTH-1:0]  init_b [VECTOR],
  input  logic [ITER_WIDTH-1:0] num_iter,
  output logic [REG_WIDTH-1:0]  a_cur  [VECTOR],
  output logic [REG_WIDTH-1:0]  b_cur  [VECTOR],
  input  logic [REG_WIDTH-1:0]  a_next [VECTOR],
  input  logic [REG_WIDTH-1:0]  b_next [VECTOR],
  output logic                  step,
  input  logic                  abort,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ITER_WIDTH-1:0] iters_done,
  output logic                  converged
);

  localparam int LAT_W = (UPDATE_LAT > 1) ? $clog2(UPDATE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(UPDATE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [REG_WIDTH-1:0]  r_a [VECTOR];
  logic [REG_WIDTH-1:0]  r_b [VECTOR];
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [ITER_WIDTH-1:0] r_remaining;
  logic [ITER_WIDTH-1:0] r_iters;

`ifdef SEQ_EARLY_EXIT_EN
  logic r_converged;
  logic w_converge;

  // Fixed point: the datapath would not change any lane this step.
  always_comb begin
    w_converge = 1'b1;
    for (int i = 0; i < VECTOR; i++) begin
      if (a_next[i] != r_a[i] || b_next[i] != r_b[i]) begin
        w_converge = 1'b0;
      end
    end
  end

  assign converged = r_converged;
`else
  assign converged = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_next_state = (num_iter == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (step) begin
          if (r_remaining == ITER_WIDTH'(1)) begin
            w_next_state = DONE;
          end
`ifdef SEQ_EARLY_EXIT_EN
          else if (w_converge) begin
            w_next_state = DONE;
          end
`endif
        end
      end
      DONE: begin
        if (abort || result_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // abort suppresses the commit, so step is gated here rather than in the datapath.
  always_comb begin
    start_ready  = 1'b0;
    result_valid = 1'b0;
    step         = 1'b0;
    case (r_state)
      IDLE:    start_ready  = 1'b1;
      RUN:     step         = (r_lat_cnt == '0) && !abort;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VECTOR; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      r_lat_cnt   <= '0;
      r_remaining <= '0;
      r_iters     <= '0;
`ifdef SEQ_EARLY_EXIT_EN
      r_converged <= 1'b0;
`endif
    end else if (r_state == IDLE && start_valid) begin
      for (int i = 0; i < VECTOR; i++) begin
        r_a[i] <= init_a[i];
        r_b[i] <= init_b[i];
      end
      r_lat_cnt   <= LAT_RELOAD;
      r_remaining <= num_iter;
      r_iters     <= '0;
`ifdef SEQ_EARLY_EXIT_EN
      r_converged <= 1'b0;
`endif
    end else if (r_state == RUN && !abort) begin
      if (step) begin
        for (int i = 0; i < VECTOR; i++) begin
          r_a[i] <= a_next[i];
          r_b[i] <= b_next[i];
        end
        r_lat_cnt   <= LAT_RELOAD;
        r_remaining <= r_remaining - 1'b1;
        r_iters     <= r_iters + 1'b1;
`ifdef SEQ_EARLY_EXIT_EN
        if (w_converge) begin
          r_converged <= 1'b1;
        end
`endif
      end else begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  assign a_cur      = r_a;
  assign b_cur      = r_b;
  assign iters_done = r_iters;

endmodule

// File: tb/tb_lut_iter_sequencer.sv
// Directed bench for lut_iter_sequencer: one instance with UPDATE_LAT=1 (A) and one with UPDATE_LAT=3 (B).
// Expectations for the early-exit case follow SEQ_EARLY_EXIT_EN.
module tb_lut_iter_sequencer;

  logic        clk;
  logic        rstN;
  logic [15:0] initA [4];
  logic [15:0] initB [4];
  logic [7:0]  numIter;
  logic        dpMode;

  logic        svA, srA, stepA, abortA, rvA, rrA, convA;
  logic [15:0] aCurA [4];
  logic [15:0] bCurA [4];
  logic [15:0] aNextA [4];
  logic [15:0] bNextA [4];
  logic [7:0]  itersA;

  logic        svB, srB, stepB, abortB, rvB, rrB, convB;
  logic [15:0] aCurB [4];
  logic [15:0] bCurB [4];
  logic [15:0] aNextB [4];
  logic [15:0] bNextB [4];
  logic [7:0]  itersB;

  int compareCount;
  int mismatchCount;
  int validAt, stepCnt, firstStep, lastStep, misplaced, unstable;

  lut_iter_sequencer #(.REG_WIDTH(16), .VECTOR(4), .ITER_WIDTH(8), .UPDATE_LAT(1)) dutA (
    .clk(clk), .rst_n(rstN), .start_valid(svA), .start_ready(srA),
    .init_a(initA), .init_b(initB), .num_iter(numIter),
    .a_cur(aCurA), .b_cur(bCurA), .a_next(aNextA), .b_next(bNextA),
    .step(stepA), .abort(abortA), .result_valid(rvA), .result_ready(rrA),
    .iters_done(itersA), .converged(convA)
  );

  lut_iter_sequencer #(.REG_WIDTH(16), .VECTOR(4), .ITER_WIDTH(8), .UPDATE_LAT(3)) dutB (
    .clk(clk), .rst_n(rstN), .start_valid(svB), .start_ready(srB),
    .init_a(initA), .init_b(initB), .num_iter(numIter),
    .a_cur(aCurB), .b_cur(bCurB), .a_next(aNextB), .b_next(bNextB),
    .step(stepB), .abort(abortB), .result_valid(rvB), .result_ready(rrB),
    .iters_done(itersB), .converged(convB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 0: a+1 / b+2. Mode 1: a saturates at 3, b unchanged.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (dpMode) begin
        aNextA[i] = ((aCurA[i] + 16'd1) > 16'd3) ? 16'd3 : (aCurA[i] + 16'd1);
        bNextA[i] = bCurA[i];
        aNextB[i] = ((aCurB[i] + 16'd1) > 16'd3) ? 16'd3 : (aCurB[i] + 16'd1);
        bNextB[i] = bCurB[i];
      end else begin
        aNextA[i] = aCurA[i] + 16'd1;
        bNextA[i] = bCurA[i] + 16'd2;
        aNextB[i] = aCurB[i] + 16'd1;
        bNextB[i] = bCurB[i] + 16'd2;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Offers a job on the selected instance and returns just after the accept edge.
  task automatic applyStimulus(input int sel, input logic [7:0] n);
    @(posedge clk);
    #1;
    numIter = n;
    if (sel == 0) svA = 1'b1; else svB = 1'b1;
    @(negedge clk);
    checkOutput("acceptReady", (sel == 0) ? srA : srB, 1);
    @(posedge clk);
    #1;
    svA = 1'b0;
    svB = 1'b0;
    numIter = 8'hAA;
  endtask

  // Cycle 1 is the cycle after the accept cycle.
  task automatic waitResult(input int sel, input int lat, input int budget);
    logic s, v;
    validAt = -1; stepCnt = 0; firstStep = -1; lastStep = -1; misplaced = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      s = (sel == 0) ? stepA : stepB;
      v = (sel == 0) ? rvA : rvB;
      if (s) begin
        stepCnt++;
        if (firstStep < 0) firstStep = c;
        lastStep = c;
        if ((c % lat) != 0) misplaced++;
      end
      if (v) begin
        validAt = c;
        break;
      end
    end
    if (validAt < 0) checkOutput("resultTimeout", 0, 1);
  endtask

  task automatic releaseResult(input int sel);
    if (sel == 0) rrA = 1'b1; else rrB = 1'b1;
    @(posedge clk);
    #1;
    rrA = 1'b0;
    rrB = 1'b0;
    @(negedge clk);
    checkOutput("releaseValidLow", (sel == 0) ? rvA : rvB, 0);
    checkOutput("releaseReadyHigh", (sel == 0) ? srA : srB, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    compareCount = 0;
    mismatchCount = 0;
    rstN = 1'b0;
    svA = 1'b1; svB = 1'b1;
    abortA = 1'b0; abortB = 1'b0;
    rrA = 1'b0; rrB = 1'b0;
    dpMode = 1'b0;
    numIter = 8'd7;
    initA = '{16'd11, 16'd12, 16'd13, 16'd14};
    initB = '{16'd21, 16'd22, 16'd23, 16'd24};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReadyA", srA, 1);
    checkOutput("rstValidA", rvA, 0);
    checkOutput("rstStepA", stepA, 0);
    checkOutput("rstItersA", itersA, 0);
    checkOutput("rstConvA", convA, 0);
    checkOutput("rstA0", aCurA[0], 0);
    checkOutput("rstB3", bCurA[3], 0);
    checkOutput("rstReadyB", srB, 1);
    @(posedge clk);
    #1;
    svA = 1'b0; svB = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", srA, 1);
    checkOutput("postRstA1", aCurA[1], 0);

    // Basic run, UPDATE_LAT=1.
    initA = '{16'd0, 16'd1, 16'd2, 16'd3};
    initB = '{16'd0, 16'd0, 16'd0, 16'd0};
    applyStimulus(0, 8'd5);
    checkOutput("basicBusyReady", srA, 0);
    waitResult(0, 1, 20);
    checkOutput("basicValidAt", validAt, 6);
    checkOutput("basicStepCnt", stepCnt, 5);
    checkOutput("basicFirstStep", firstStep, 1);
    checkOutput("basicLastStep", lastStep, 5);
    checkOutput("basicIters", itersA, 5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("basicA", aCurA[i], 5 + i);
      checkOutput("basicB", bCurA[i], 10);
    end
    releaseResult(0);

    // UPDATE_LAT=3 with back-pressure.
    applyStimulus(1, 8'd4);
    waitResult(1, 3, 40);
    checkOutput("lat3ValidAt", validAt, 13);
    checkOutput("lat3StepCnt", stepCnt, 4);
    checkOutput("lat3FirstStep", firstStep, 3);
    checkOutput("lat3LastStep", lastStep, 12);
    checkOutput("lat3Misplaced", misplaced, 0);
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rvB || aCurB[0] != 16'd4 || bCurB[1] != 16'd8 || srB) unstable++;
    end
    checkOutput("lat3HoldStable", unstable, 0);
    checkOutput("lat3A3", aCurB[3], 7);
    checkOutput("lat3Iters", itersB, 4);
    releaseResult(1);

    // Zero iterations: result equals init the cycle after accept.
    initA = '{16'd9, 16'd8, 16'd7, 16'd6};
    initB = '{16'd1, 16'd2, 16'd3, 16'd4};
    applyStimulus(0, 8'd0);
    waitResult(0, 1, 5);
    checkOutput("zeroValidAt", validAt, 1);
    checkOutput("zeroStepCnt", stepCnt, 0);
    checkOutput("zeroIters", itersA, 0);
    checkOutput("zeroA0", aCurA[0], 9);
    checkOutput("zeroB3", bCurA[3], 4);
    checkOutput("zeroBusyReady", srA, 0);
    releaseResult(0);

    // Abort on the second step cycle.
    initA = '{16'd0, 16'd0, 16'd0, 16'd0};
    initB = '{16'd0, 16'd0, 16'd0, 16'd0};
    applyStimulus(0, 8'd10);
    @(posedge clk);
    #1;
    abortA = 1'b1;
    @(negedge clk);
    checkOutput("abortNoStep", stepA, 0);
    @(posedge clk);
    #1;
    abortA = 1'b0;
    @(negedge clk);
    checkOutput("abortIdleReady", srA, 1);
    checkOutput("abortValid", rvA, 0);
    checkOutput("abortIters", itersA, 1);
    checkOutput("abortA0", aCurA[0], 1);
    checkOutput("abortB0", bCurA[0], 2);
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rvA) unstable++;
    end
    checkOutput("abortNoResult", unstable, 0);
    applyStimulus(0, 8'd1);
    waitResult(0, 1, 10);
    checkOutput("afterAbortValidAt", validAt, 2);
    checkOutput("afterAbortIters", itersA, 1);
    releaseResult(0);

    // Full-range iteration count.
    applyStimulus(0, 8'd255);
    waitResult(0, 1, 300);
    checkOutput("maxValidAt", validAt, 256);
    checkOutput("maxIters", itersA, 255);
    checkOutput("maxA0", aCurA[0], 255);
    checkOutput("maxB0", bCurA[0], 510);
    releaseResult(0);

    // Fixed-point datapath: early exit only when the feature is built in.
    dpMode = 1'b1;
    applyStimulus(0, 8'd20);
    waitResult(0, 1, 40);
`ifdef SEQ_EARLY_EXIT_EN
    checkOutput("exitValidAt", validAt, 5);
    checkOutput("exitIters", itersA, 4);
    checkOutput("exitConverged", convA, 1);
`else
    checkOutput("exitValidAt", validAt, 21);
    checkOutput("exitIters", itersA, 20);
    checkOutput("exitConverged", convA, 0);
`endif
    checkOutput("exitA2", aCurA[2], 3);
    releaseResult(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
